// File: rtl/seven_seg_scan.sv
// Binary-to-BCD converter (double dabble) driving a multiplexed active-low seven-segment display.
// Conversion takes WIDTH+1 clocks after load; seg/an are registered and change only at scan-slot boundaries.
// load is ignored while busy; optional leading-zero blanking when SEVEN_SEG_LZ_BLANK_EN is defined.
module seven_seg_scan #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WIDTH-1:0]  value,
  output logic              busy,
  output logic              overflow,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  // Decimal digits needed to hold 2^w-1.
  function automatic int num_digits(input int w);
    int v;
    int n;
    v = (1 << w) - 1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (v > 0) begin
        n++;
        v = v / 10;
      end
    end
    return n;
  endfunction

  localparam int NB  = num_digits(WIDTH);
  // Accumulator covers both the full input range and every displayed position.
  localparam int ACC = (NB > DIGITS) ? NB : DIGITS;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [6:0] GLYPH_DASH  = 7'b1111110;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b0000001;
      4'd1:    glyph = 7'b1001111;
      4'd2:    glyph = 7'b0010010;
      4'd3:    glyph = 7'b0000110;
      4'd4:    glyph = 7'b1001100;
      4'd5:    glyph = 7'b0100100;
      4'd6:    glyph = 7'b0100000;
      4'd7:    glyph = 7'b0001111;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0001100;
      default: glyph = GLYPH_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    sh;
  logic [ACC*4-1:0]    bcd, bcd_adj;
  logic                ovf_calc;
  logic [DIGITS*4-1:0] disp;
  logic                disp_ovf;
  logic [DW-1:0]       div;
  logic [IW-1:0]       idx;
  logic [3:0]          cur_dig;
  logic [6:0]          seg_nxt;
  logic [DIGITS-1:0]   an_nxt;

  // Conversion state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and busy decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE:   if (load) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_nxt = COMMIT;
      end
      COMMIT: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Add 3 to every BCD digit of 5 or more before the next shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < ACC; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Overflow when any digit beyond the displayed ones is nonzero.
  always_comb begin
    ovf_calc = 1'b0;
    for (int i = DIGITS; i < ACC; i++) begin
      if (bcd[4*i +: 4] != 4'd0) ovf_calc = 1'b1;
    end
  end

  // Conversion datapath; the display register only changes in COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh       <= '0;
      cnt      <= '0;
      bcd      <= '0;
      disp     <= '0;
      disp_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            sh  <= value;
            bcd <= '0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sh  <= {sh[WIDTH-2:0], 1'b0};
          bcd <= {bcd_adj[ACC*4-2:0], sh[WIDTH-1]};
          cnt <= cnt + 1'b1;
        end
        COMMIT: begin
          disp     <= bcd[DIGITS*4-1:0];
          disp_ovf <= ovf_calc;
        end
        default: ;
      endcase
    end
  end

  assign overflow = disp_ovf;

`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic [DIGITS-1:0] lead_zero;
  logic              zero_above;

  // lead_zero[i] is set when digit i and every digit above it are zero.
  always_comb begin
    lead_zero  = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above   = zero_above & (disp[4*i +: 4] == 4'd0);
      lead_zero[i] = zero_above;
    end
  end
`endif

  // Glyph and digit enable for the slot about to start.
  always_comb begin
    cur_dig = 4'd0;
    an_nxt  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_dig   = disp[4*i +: 4];
        an_nxt[i] = 1'b0;
      end
    end
    if (disp_ovf) begin
      seg_nxt = GLYPH_DASH;
    end else begin
      seg_nxt = glyph(cur_dig);
`ifdef SEVEN_SEG_LZ_BLANK_EN
      for (int i = 1; i < DIGITS; i++) begin
        if (idx == IW'(i) && lead_zero[i]) seg_nxt = GLYPH_BLANK;
      end
`endif
    end
  end

  // Free-running scan: seg/an load together at each slot boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
      seg <= GLYPH_BLANK;
      an  <= '1;
    end else begin
      if (div == '0) begin
        seg <= seg_nxt;
        an  <= an_nxt;
      end
      if (div == DW'(SCAN_DIV - 1)) begin
        div <= '0;
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: default instance plus a DIGITS=2 instance.
// Checks reset, conversion latency, glyphs, overflow dashes, load dropping, reset abort and scan rotation.
// Leading-zero expectations follow SEVEN_SEG_LZ_BLANK_EN.
module tb_seven_seg_scan;

  localparam logic [6:0] G0 = 7'b0000001;
  localparam logic [6:0] G1 = 7'b1001111;
  localparam logic [6:0] G2 = 7'b0010010;
  localparam logic [6:0] G4 = 7'b1001100;
  localparam logic [6:0] G5 = 7'b0100100;
  localparam logic [6:0] G6 = 7'b0100000;
  localparam logic [6:0] G7 = 7'b0001111;
  localparam logic [6:0] GD = 7'b1111110;
  localparam logic [6:0] GB = 7'b1111111;
`ifdef SEVEN_SEG_LZ_BLANK_EN
  localparam logic [6:0] GLZ = GB;
`else
  localparam logic [6:0] GLZ = G0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       load, load2;
  logic [7:0] value, value2;
  logic       busy, busy2, overflow, overflow2;
  logic [6:0] seg, seg2;
  logic [2:0] an;
  logic [1:0] an2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seven_seg_scan dut (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .busy(busy), .overflow(overflow), .seg(seg), .an(an)
  );

  seven_seg_scan #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(4)) dut2 (
    .clk(clk), .rst(rst), .load(load2), .value(value2),
    .busy(busy2), .overflow(overflow2), .seg(seg2), .an(an2)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_idle(input int which);
    int n;
    n = 0;
    while ((((which == 0) ? busy : busy2) === 1'b1) && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("idle_timeout", {7'd0, n < 100}, 8'd1);
  endtask

  // Return the glyph shown while digit d is enabled, after the display has settled.
  task automatic capture(input int which, input int d, output logic [6:0] s);
    logic [2:0] t3;
    logic [1:0] t2;
    logic       hit;
    int         n;
    t3  = 3'b1 << d;
    t3  = ~t3;
    t2  = 2'b1 << d;
    t2  = ~t2;
    hit = 1'b0;
    s   = 7'bx;
    repeat (16) @(negedge clk);
    for (n = 0; n < 64 && !hit; n++) begin
      if ((which == 0 && an === t3) || (which == 1 && an2 === t2)) begin
        hit = 1'b1;
        s   = (which == 0) ? seg : seg2;
      end else begin
        @(negedge clk);
      end
    end
    chk("capture_timeout", {7'd0, hit}, 8'd1);
  endtask

  logic [6:0] s;
  logic [2:0] an_exp;
  int         n;

  initial begin
    rst = 1'b1; load = 1'b0; load2 = 1'b0; value = '0; value2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_seg", {1'b0, seg}, {1'b0, GB});
    chk("rst_an", {5'd0, an}, 8'b111);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_ovf", {7'd0, overflow}, 8'd0);
    chk("rst_an2", {6'd0, an2}, 8'b11);

    // Release reset; scan rotates from digit 0 on the very first clock.
    rst = 1'b0;
    @(negedge clk);
    chk("first_seg", {1'b0, seg}, {1'b0, G0});
    for (int c = 0; c < 36; c++) begin
      an_exp = 3'b1 << ((c / 4) % 3);
      an_exp = ~an_exp;
      chk("an_rot", {5'd0, an}, {5'd0, an_exp});
      @(negedge clk);
    end

    // 142: busy for exactly 9 clocks, digits 1 4 2.
    pulse(8'd142);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", n[7:0], 8'd9);
    chk("ovf_142", {7'd0, overflow}, 8'd0);
    capture(0, 0, s); chk("d0_142", {1'b0, s}, {1'b0, G2});
    capture(0, 1, s); chk("d1_142", {1'b0, s}, {1'b0, G4});
    capture(0, 2, s); chk("d2_142", {1'b0, s}, {1'b0, G1});

    // Load while busy is dropped.
    pulse(8'd5);
    repeat (2) @(negedge clk);
    pulse(8'd9);
    wait_idle(0);
    capture(0, 0, s); chk("d0_5", {1'b0, s}, {1'b0, G5});
    capture(0, 1, s); chk("d1_5", {1'b0, s}, {1'b0, GLZ});

    // Leading zeros.
    pulse(8'd7);
    wait_idle(0);
    capture(0, 0, s); chk("d0_7", {1'b0, s}, {1'b0, G7});
    capture(0, 1, s); chk("d1_7", {1'b0, s}, {1'b0, GLZ});
    capture(0, 2, s); chk("d2_7", {1'b0, s}, {1'b0, GLZ});

    // Load presented in the first idle clock is accepted.
    pulse(8'd3);
    wait_idle(0);
    pulse(8'd6);
    chk("accept_at_fall", {7'd0, busy}, 8'd1);
    wait_idle(0);
    capture(0, 0, s); chk("d0_6", {1'b0, s}, {1'b0, G6});

    // DIGITS=2 overflow shows dashes.
    value2 = 8'd100;
    load2  = 1'b1;
    @(negedge clk);
    load2  = 1'b0;
    wait_idle(1);
    chk("ovf2", {7'd0, overflow2}, 8'd1);
    capture(1, 0, s); chk("d0_ovf2", {1'b0, s}, {1'b0, GD});
    capture(1, 1, s); chk("d1_ovf2", {1'b0, s}, {1'b0, GD});

    // Reset during SHIFT aborts with no commit.
    pulse(8'd255);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_seg", {1'b0, seg}, {1'b0, GB});
    chk("abort_an", {5'd0, an}, 8'b111);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_ovf2", {7'd0, overflow2}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_an", {5'd0, an}, 8'b110);
    chk("post_seg", {1'b0, seg}, {1'b0, G0});
    chk("post_busy", {7'd0, busy}, 8'd0);
    repeat (20) @(negedge clk);
    chk("post_busy_late", {7'd0, busy}, 8'd0);
    capture(0, 0, s); chk("post_d0", {1'b0, s}, {1'b0, G0});
    capture(0, 2, s); chk("post_d2", {1'b0, s}, {1'b0, GLZ});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter WIDTH, default 8: binary input width; legal range 4..16.
REQ-002 Parameter DIGITS, default 3: number of displayed decimal digits; legal range 1..5.
REQ-003 Parameter SCAN_DIV, default 4: clocks per digit scan slot; minimum 1.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 load  in  1  single-cycle request to convert and display value.
REQ-007 value  in  WIDTH  unsigned binary number to display.
REQ-008 busy  out  1  conversion in progress; load ignored while high.
REQ-009 overflow  out  1  last committed value exceeded 10^DIGITS-1.
REQ-010 seg  out  7  segments {a,b,c,d,e,f,g}, a is MSB, active-low.
REQ-011 an  out  DIGITS  digit enables, active-low, one-hot; bit 0 is the least significant digit.

Function
REQ-012 Glyphs on seg for digit 0..9 SHALL be 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0001100; dash SHALL be 1111110; blank SHALL be 1111111.
REQ-013 Conversion FSM states SHALL be IDLE, SHIFT, COMMIT.
REQ-014 IDLE: load=1 SHALL capture value, clear the BCD accumulator, and go to SHIFT.
REQ-015 SHIFT: shift-add-3 (double dabble) SHALL process one input bit per clock, MSB first, for exactly WIDTH clocks, then go to COMMIT.
REQ-016 COMMIT: BCD digits and overflow flag SHALL be written to the display register in one clock, then go to IDLE.
REQ-017 busy SHALL be high in SHIFT and COMMIT: WIDTH+1 clocks after the clock that samples load.
REQ-018 load while busy=1 SHALL be dropped with no queuing; load in the clock busy falls SHALL be accepted.
REQ-019 The BCD accumulator SHALL be wide enough for 2^WIDTH-1; overflow SHALL be set when any digit above DIGITS-1 is nonzero.
REQ-020 With overflow=1, every digit position SHALL show dash.
REQ-021 The display register SHALL hold its previous contents until COMMIT; the scan SHALL never show partial conversion results.
REQ-022 The scan counter SHALL advance the active digit every SCAN_DIV clocks: 0,1,...,DIGITS-1, then wrap to 0, independent of the FSM.
REQ-023 seg and an SHALL be registered and change together at each slot boundary; exactly one an bit SHALL be low.
REQ-024 A value committed mid-slot SHALL appear from the next slot boundary.

Reset
REQ-025 rst=1 SHALL force IDLE, busy=0, overflow=0, the display register to zero, the scan index and divider to 0, seg=1111111, and an all ones.
REQ-026 rst asserted mid-conversion SHALL abort the conversion with no commit.
REQ-027 The first clock after rst deasserts SHALL drive an bit 0 low with the digit-0 glyph.

Configuration
REQ-028 Macro SEVEN_SEG_LZ_BLANK_EN defined: any zero digit above the most significant nonzero digit SHALL show blank; digit 0 SHALL always show its glyph; dashes (overflow) SHALL be unaffected.
REQ-029 Macro SEVEN_SEG_LZ_BLANK_EN undefined: all DIGITS positions SHALL show their decimal glyph, including leading zeros.

Verification
REQ-030 Defaults: load with value=8'd142 -> busy high for exactly 9 clocks; slots then show digit2=1001111, digit1=1001100, digit0=0010010; overflow=0.
REQ-031 DIGITS=2: load with value=8'd100 -> overflow=1; both slots show 1111110.
REQ-032 Load 8'd5, then pulse load with 8'd9 while busy -> display shows 5; the second load has no effect.
REQ-033 SEVEN_SEG_LZ_BLANK_EN defined: load 8'd7 -> digit2 and digit1 show 1111111, digit0 shows 0001111; undefined -> digit2 and digit1 show 0000001.
REQ-034 Load 8'd255, assert rst on the 4th SHIFT clock -> outputs take reset values immediately; after release, digit0 shows 0000001 and busy=0.
REQ-035 Free-running scan for 3*SCAN_DIV*DIGITS clocks -> an rotates 110,101,011 with no zero-low or multi-low cycles.
